// File: rtl/alu_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_loader_pkg
// Purpose  : Shared types and constants for the ALU operand loader. This
//            covers the FSM state encoding, default widths and the ALU
//            opcode values.
// Revision : 1.0 - initial release
// ============================================================================
package alu_loader_pkg;

    localparam int DEF_NBITS  = 8;
    localparam int DEF_COD_OP = 6;

    // Encodings are visible on the debug LEDs, so keep them fixed
    typedef enum logic [1:0] {
        WAIT_A  = 2'd0,
        WAIT_B  = 2'd1,
        WAIT_OP = 2'd2,
        EXEC    = 2'd3
    } state_t;

    // ALU opcodes (MIPS-style funct values)
    localparam logic [DEF_COD_OP-1:0] ADD = 6'b100000;
    localparam logic [DEF_COD_OP-1:0] SUB = 6'b100010;
    localparam logic [DEF_COD_OP-1:0] AND = 6'b100100;
    localparam logic [DEF_COD_OP-1:0] OR  = 6'b100101;
    localparam logic [DEF_COD_OP-1:0] XOR = 6'b100110;
    localparam logic [DEF_COD_OP-1:0] SRA = 6'b000011;
    localparam logic [DEF_COD_OP-1:0] SRL = 6'b000010;
    localparam logic [DEF_COD_OP-1:0] NOR = 6'b100111;

endpackage
`default_nettype wire

// File: rtl/alu_operand_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_operand_loader_if
// Purpose  : Board/ALU-side signal bundle of the operand loader. The master
//            side is the board plus ALU; the slave side is the loader.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_operand_loader_if
    import alu_loader_pkg::*;
#(
    parameter int NBITS  = DEF_NBITS,
    parameter int COD_OP = DEF_COD_OP
) ();

    logic [NBITS-1:0]  switches;
    logic              btn_a;
    logic              btn_b;
    logic              btn_op;
    logic [NBITS-1:0]  alu_result;
    logic [NBITS-1:0]  operando_A;
    logic [NBITS-1:0]  operando_B;
    logic [COD_OP-1:0] cod_operacion;
    logic              op_valid;
    logic [NBITS-1:0]  leds;
    logic [1:0]        estado;

    modport master (
        output switches, btn_a, btn_b, btn_op, alu_result,
        input  operando_A, operando_B, cod_operacion, op_valid, leds, estado
    );

    modport slave (
        input  switches, btn_a, btn_b, btn_op, alu_result,
        output operando_A, operando_B, cod_operacion, op_valid, leds, estado
    );

endinterface
`default_nettype wire

// File: rtl/boton_debounce.sv
`default_nettype none
// ============================================================================
// Module   : boton_debounce
// Purpose  : Raw push-button to single-cycle load pulse. The path is a 2-FF
//            synchroniser, then a counter debouncer, then a registered
//            rising-edge detect.
// Revision : 1.0 - initial release
// ============================================================================
module boton_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic btn_raw,
    output logic      pulse
);

    localparam int c_cnt_w = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic [1:0]         r_sync;
    logic               r_level;
    logic               r_level_d;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_pulse;

    // Two-stage synchroniser for the asynchronous button input
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], btn_raw};
        end
    end

    // Accept a level change only after DEBOUNCE_CYCLES consecutive differing cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else if (r_sync[1] != r_level) begin
            if (r_cnt == c_cnt_last) begin
                r_level <= r_sync[1];
                r_cnt   <= '0;
            end else begin
                r_cnt   <= r_cnt + c_cnt_w'(1);
            end
        end else begin
            r_cnt <= '0;
        end
    end

    // Registered rising-edge detect; falling edges give no pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_level_d <= 1'b0;
            r_pulse   <= 1'b0;
        end else begin
            r_level_d <= r_level;
            r_pulse   <= r_level & ~r_level_d;
        end
    end

    assign pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/alu_operand_loader.sv
`default_nettype none
// ============================================================================
// Module   : alu_operand_loader
// Purpose  : Loads operand A, operand B and the opcode in that order from a
//            shared switch bank, drives them to the ALU, and captures the
//            ALU result into the LED register.
// Revision : 1.0 - initial release
// ============================================================================
module alu_operand_loader
    import alu_loader_pkg::*;
#(
    parameter int NBITS           = DEF_NBITS,
    parameter int COD_OP          = DEF_COD_OP,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  wire logic             clk,
    input  wire logic             reset,
    alu_operand_loader_if.slave   bus
);

    logic w_pulse_a;
    logic w_pulse_b;
    logic w_pulse_op;

    boton_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbnc_a (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (bus.btn_a),
        .pulse   (w_pulse_a)
    );

    boton_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbnc_b (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (bus.btn_b),
        .pulse   (w_pulse_b)
    );

    boton_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbnc_op (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (bus.btn_op),
        .pulse   (w_pulse_op)
    );

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_load_a;
    logic              w_load_b;
    logic              w_load_op;
    logic              w_exec;
    logic [NBITS-1:0]  r_operand_a;
    logic [NBITS-1:0]  r_operand_b;
    logic [COD_OP-1:0] r_opcode;
    logic [NBITS-1:0]  r_leds;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= WAIT_A;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and load strobes; a pulse not matching the state is dropped
    always_comb begin
        w_state_nxt = r_state;
        w_load_a    = 1'b0;
        w_load_b    = 1'b0;
        w_load_op   = 1'b0;
        w_exec      = 1'b0;
        case (r_state)
            WAIT_A: begin
                if (w_pulse_a) begin
                    w_load_a    = 1'b1;
                    w_state_nxt = WAIT_B;
                end
            end
            WAIT_B: begin
                if (w_pulse_b) begin
                    w_load_b    = 1'b1;
                    w_state_nxt = WAIT_OP;
                end
            end
            WAIT_OP: begin
                if (w_pulse_op) begin
                    w_load_op   = 1'b1;
                    w_state_nxt = EXEC;
                end
            end
            EXEC: begin
                w_exec      = 1'b1;
                w_state_nxt = WAIT_A;
            end
            default: begin
                w_state_nxt = WAIT_A;
            end
        endcase
    end

    // Operand, opcode and result registers; each holds until its next load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_operand_a <= '0;
            r_operand_b <= '0;
            r_opcode    <= '0;
            r_leds      <= '0;
        end else begin
            if (w_load_a) begin
                r_operand_a <= bus.switches;
            end
            if (w_load_b) begin
                r_operand_b <= bus.switches;
            end
            if (w_load_op) begin
                r_opcode <= bus.switches[COD_OP-1:0];
            end
            if (w_exec) begin
                r_leds <= bus.alu_result;
            end
        end
    end

    assign bus.operando_A    = r_operand_a;
    assign bus.operando_B    = r_operand_b;
    assign bus.cod_operacion = r_opcode;
    assign bus.op_valid      = w_exec;
    assign bus.leds          = r_leds;
    assign bus.estado        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_alu_operand_loader
// Purpose  : Self-checking bench for alu_operand_loader. A behavioural ALU
//            answers the DUT, and a sequence model predicts the loads. A
//            scoreboard queue checks every executed operation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_operand_loader;
    import alu_loader_pkg::*;

    localparam int NB = 8;
    localparam int CO = 6;
    localparam int DB = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    alu_operand_loader_if #(.NBITS(NB), .COD_OP(CO)) bus ();

    alu_operand_loader #(
        .NBITS           (NB),
        .COD_OP          (CO),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [NB-1:0] a;
        logic [NB-1:0] b;
        logic [CO-1:0] op;
        logic [NB-1:0] res;
    } exp_t;

    int   checks     = 0;
    int   failures   = 0;
    int   ops_issued = 0;
    int   ops_seen   = 0;
    exp_t sb_q[$];

    // Model of the loading sequence: how many items of the current triple are in
    int            m_state;
    logic [NB-1:0] m_a;
    logic [NB-1:0] m_b;
    logic [CO-1:0] m_op;
    logic [NB-1:0] m_leds;

    logic [CO-1:0] op_tab [8] = '{ADD, SUB, AND, OR, XOR, SRA, SRL, NOR};

    function automatic logic [NB-1:0] alu_ref(logic [NB-1:0] a, logic [NB-1:0] b,
                                              logic [CO-1:0] op);
        logic signed [NB-1:0] sa;
        sa = a;
        case (op)
            ADD:     return a + b;
            SUB:     return a - b;
            AND:     return a & b;
            OR:      return a | b;
            XOR:     return a ^ b;
            SRA:     return sa >>> b;
            SRL:     return a >> b;
            NOR:     return ~(a | b);
            default: return '0;
        endcase
    endfunction

    // Combinational ALU seen by the DUT
    always_comb bus.alu_result = alu_ref(bus.operando_A, bus.operando_B, bus.cod_operacion);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_estado"}, 32'(bus.estado), 32'(m_state));
        check({tag, "_opA"},    32'(bus.operando_A), 32'(m_a));
        check({tag, "_opB"},    32'(bus.operando_B), 32'(m_b));
        check({tag, "_cod"},    32'(bus.cod_operacion), 32'(m_op));
        check({tag, "_leds"},   32'(bus.leds), 32'(m_leds));
    endtask

    task automatic model_reset();
        m_state = 0;
        m_a     = '0;
        m_b     = '0;
        m_op    = '0;
        m_leds  = '0;
    endtask

    // Press the buttons in mask = {op, b, a}, optionally bouncing first, then release
    task automatic press(input string tag, input logic [2:0] mask, input logic [NB-1:0] sw,
                         input bit bounce, input int hold);
        bit         accept;
        int         lat;
        logic [1:0] st0;
        accept = 1'b0;
        if (m_state == 0 && mask[0]) begin
            m_a = sw; m_state = 1; accept = 1'b1;
        end else if (m_state == 1 && mask[1]) begin
            m_b = sw; m_state = 2; accept = 1'b1;
        end else if (m_state == 2 && mask[2]) begin
            m_op   = sw[CO-1:0];
            m_leds = alu_ref(m_a, m_b, m_op);
            sb_q.push_back('{m_a, m_b, m_op, m_leds});
            ops_issued++;
            m_state = 0;
            accept  = 1'b1;
        end
        @(negedge clk);
        bus.switches = sw;
        if (bounce) begin
            for (int i = 0; i < 10; i++) begin
                {bus.btn_op, bus.btn_b, bus.btn_a} = (i % 2 == 0) ? mask : 3'b000;
                repeat (2) @(negedge clk);
            end
        end
        st0 = bus.estado;
        {bus.btn_op, bus.btn_b, bus.btn_a} = mask;
        lat = 0;
        for (int k = 1; k <= hold; k++) begin
            @(negedge clk);
            if (lat == 0 && bus.estado !== st0) lat = k;
        end
        check({tag, "_latency"}, 32'(lat), accept ? 32'(DB + 4) : 32'd0);
        {bus.btn_op, bus.btn_b, bus.btn_a} = 3'b000;
        repeat (14) @(negedge clk);
        check_outputs(tag);
    endtask

    // Monitor: every op_valid must match the oldest expected operation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && bus.op_valid === 1'b1) begin
                ops_seen++;
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_op_valid actual=1 required=0 at %0t", $time);
                end else begin
                    e = sb_q.pop_front();
                    check("exec_opA", 32'(bus.operando_A), 32'(e.a));
                    check("exec_opB", 32'(bus.operando_B), 32'(e.b));
                    check("exec_cod", 32'(bus.cod_operacion), 32'(e.op));
                    check("exec_estado", 32'(bus.estado), 32'd3);
                    @(negedge clk);
                    check("exec_leds", 32'(bus.leds), 32'(e.res));
                    check("op_valid_width", 32'(bus.op_valid), 32'd0);
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0]    mask;
        logic [NB-1:0] sw;
        reset        = 1'b1;
        bus.switches = '0;
        bus.btn_a    = 1'b0;
        bus.btn_b    = 1'b0;
        bus.btn_op   = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs("reset");
        check("reset_op_valid", 32'(bus.op_valid), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Out-of-order B press in WAIT_A
        press("order_b", 3'b010, 8'hFF, 1'b0, 12);

        // Directed ADD sequence: 5 + 3
        press("dir_a",  3'b001, 8'h05, 1'b0, 12);
        press("dir_b",  3'b010, 8'h03, 1'b0, 12);
        press("dir_op", 3'b100, 8'h20, 1'b0, 12);
        check("dir_add_leds", 32'(bus.leds), 32'h08);

        // Bounced A press, then finish the triple
        press("bounce_a", 3'b001, 8'h5A, 1'b1, 12);
        press("seq_b",    3'b010, 8'h07, 1'b0, 12);
        press("seq_op",   3'b100, {2'b11, SUB}, 1'b0, 12);

        // Simultaneous A and B in WAIT_A
        press("simul_ab", 3'b011, 8'hC3, 1'b0, 12);
        press("simul_b",  3'b010, 8'h02, 1'b0, 12);
        press("simul_op", 3'b100, {2'b01, SRA}, 1'b0, 12);

        // Held A for 100 cycles, then a second A press in WAIT_B
        press("held_a",   3'b001, 8'h3C, 1'b0, 100);
        press("again_a",  3'b001, 8'hAA, 1'b0, 12);
        press("held_b",   3'b010, 8'h0F, 1'b0, 12);
        press("held_op",  3'b100, {2'b10, XOR}, 1'b0, 12);

        // Asynchronous reset after A and B loaded
        press("rst_a", 3'b001, 8'h11, 1'b0, 12);
        press("rst_b", 3'b010, 8'h22, 1'b0, 12);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs("async_rst");
        check("async_rst_op_valid", 32'(bus.op_valid), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        press("post_rst_b", 3'b010, 8'h99, 1'b0, 12);

        // Randomised presses: mostly in order, sometimes arbitrary combinations
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 9) < 7) mask = 3'b001 << m_state;
            else                          mask = 3'($urandom_range(1, 7));
            sw = NB'($urandom);
            if (mask[2] && $urandom_range(0, 3) != 0)
                sw[CO-1:0] = op_tab[$urandom_range(0, 7)];
            press("rand", mask, sw, 1'($urandom_range(0, 1)), $urandom_range(12, 30));
        end

        repeat (20) @(negedge clk);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        check("ops_count", 32'(ops_seen), 32'(ops_issued));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
